// File: rtl/mod_mul_iter.sv
// mod_mul_iter: iterative modular multiplier, o_result = (a * b) mod n.
//
// Uses interleaved shift-and-add. Each RUN cycle consumes DIGIT bits of a, LSB first.
// Accumulator m and multiplicand t both stay below n. Operand length LEN is chosen
// per operation by i_mode: LEN = MAX_BITS >> (3 - i_mode).
//
// Optional feature: define MODMUL_EARLY_EXIT_EN to leave RUN as soon as the remaining
// bits of a are all zero. Results are identical with or without it; only latency differs.
//
// Parameters
//   MAX_BITS  maximum operand width (multiple of 8)
//   DIGIT     bits of a consumed per RUN cycle (1, 2 or 4)
// Ports
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_start   start request, sampled only in IDLE
//   i_mode    operand length select (32/64/128/256 bits at default MAX_BITS)
//   i_n       modulus
//   i_a, i_b  multiplicands
//   o_result  (a*b) mod n, registered, zero above LEN
//   o_valid   one-cycle pulse when o_result/o_err are new
//   o_busy    high in RUN and DONE
//   o_err     operand error (n == 0 or b >= n), qualified by o_valid
module mod_mul_iter #(
  parameter int unsigned MAX_BITS = 256,
  parameter int unsigned DIGIT    = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic [MAX_BITS-1:0] i_n,
  input  logic [MAX_BITS-1:0] i_a,
  input  logic [MAX_BITS-1:0] i_b,
  output logic [MAX_BITS-1:0] o_result,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_err
);

  localparam int unsigned CntW = $clog2(MAX_BITS / DIGIT + 1);
  localparam logic [MAX_BITS-1:0] Ones = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [1:0]          r_mode;
  logic [MAX_BITS-1:0] r_n, r_a, r_m, r_t;
  logic [CntW-1:0]     r_cnt;
  logic [MAX_BITS-1:0] r_result;
  logic                r_err;

  logic [MAX_BITS-1:0] w_mask_in;
  logic [MAX_BITS-1:0] w_n_in, w_a_in, w_b_in;
  logic                w_bad;
  logic [CntW-1:0]     w_last;
  logic                w_run_end;
  logic [MAX_BITS-1:0] w_m, w_t;
  logic [MAX_BITS:0]   w_sum, w_dbl;

  // Length mask for the incoming request.
  always_comb begin
    w_mask_in = Ones;
    unique case (i_mode)
      2'd0: w_mask_in = Ones >> (MAX_BITS - MAX_BITS / 8);
      2'd1: w_mask_in = Ones >> (MAX_BITS - MAX_BITS / 4);
      2'd2: w_mask_in = Ones >> (MAX_BITS - MAX_BITS / 2);
      2'd3: w_mask_in = Ones;
    endcase
  end

  assign w_n_in = i_n & w_mask_in;
  assign w_a_in = i_a & w_mask_in;
  assign w_b_in = i_b & w_mask_in;
  assign w_bad  = (w_n_in == '0) || (w_b_in >= w_n_in);

  // Index of the final RUN cycle for the latched length.
  always_comb begin
    w_last = '0;
    unique case (r_mode)
      2'd0: w_last = CntW'(MAX_BITS / 8 / DIGIT - 1);
      2'd1: w_last = CntW'(MAX_BITS / 4 / DIGIT - 1);
      2'd2: w_last = CntW'(MAX_BITS / 2 / DIGIT - 1);
      2'd3: w_last = CntW'(MAX_BITS / DIGIT - 1);
    endcase
  end

  // DIGIT interleaved add/double sub-steps. The sums are one bit wider than the operands.
  // m and t stay below n, so a single conditional subtract keeps them reduced.
  always_comb begin
    w_m   = r_m;
    w_t   = r_t;
    w_sum = '0;
    w_dbl = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (r_a[j]) begin
        w_sum = {1'b0, w_m} + {1'b0, w_t};
        if (w_sum >= {1'b0, r_n}) w_sum = w_sum - {1'b0, r_n};
        w_m = w_sum[MAX_BITS-1:0];
      end
      w_dbl = {w_t, 1'b0};
      if (w_dbl >= {1'b0, r_n}) w_dbl = w_dbl - {1'b0, r_n};
      w_t = w_dbl[MAX_BITS-1:0];
    end
  end

`ifdef MODMUL_EARLY_EXIT_EN
  // Stop once no set bits of a remain beyond this cycle's digit.
  assign w_run_end = (r_cnt == w_last) || ((r_a >> DIGIT) == '0);
`else
  assign w_run_end = (r_cnt == w_last);
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (i_start) w_state_d = w_bad ? StDone : StRun;
      StRun:  if (w_run_end) w_state_d = StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_mode   <= '0;
      r_n      <= '0;
      r_a      <= '0;
      r_m      <= '0;
      r_t      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && i_start) begin
        r_mode <= i_mode;
        r_n    <= w_n_in;
        r_a    <= w_a_in;
        r_t    <= w_b_in;
        r_m    <= '0;
        r_cnt  <= '0;
        if (w_bad) begin
          r_result <= '0;
          r_err    <= 1'b1;
        end
      end else if (r_state == StRun) begin
        r_m   <= w_m;
        r_t   <= w_t;
        r_a   <= r_a >> DIGIT;
        r_cnt <= r_cnt + 1'b1;
        if (w_run_end) begin
          r_result <= w_m;
          r_err    <= 1'b0;
        end
      end
    end
  end

  assign o_result = r_result;
  assign o_err    = r_err;
  assign o_valid  = (r_state == StDone);
  assign o_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_mod_mul_iter.sv
module tb_mod_mul_iter;

  localparam int unsigned MaxBits = 256;
  localparam int unsigned Digit   = 1;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic [1:0]         i_mode;
  logic [MaxBits-1:0] i_n, i_a, i_b;
  logic [MaxBits-1:0] o_result;
  logic               o_valid, o_busy, o_err;

  mod_mul_iter #(.MAX_BITS(MaxBits), .DIGIT(Digit)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_mode   (i_mode),
    .i_n      (i_n),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_result (o_result),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_err    (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [MaxBits-1:0] res;
    logic               err;
    int                 vcyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic               hold_chk = 1'b0;
  logic [MaxBits-1:0] last_res = '0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Expected cycle (1 = first cycle after the start edge) of the o_valid pulse.
  function automatic int lat_of(input logic [1:0] mode, input logic [MaxBits-1:0] a,
                                input bit err);
    int len;
    int nb;
    int k;
    len = int'(MaxBits >> (3 - int'(mode)));
    nb  = 0;
    k   = len / int'(Digit);
    if (err) return 1;
`ifdef MODMUL_EARLY_EXIT_EN
    for (int i = 0; i < len; i++) if (a[i]) nb = i + 1;
    k = (nb + int'(Digit) - 1) / int'(Digit);
    if (k < 1) k = 1;
`endif
    return k + 1;
  endfunction

  task automatic check(input string name, input logic [MaxBits-1:0] act,
                       input logic [MaxBits-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (hold_chk) begin
        hold_chk = 1'b0;
        check("done_to_idle_busy", MaxBits'(o_busy), '0);
        check("result_hold", o_result, last_res);
      end
      if (o_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", MaxBits'(o_valid), '0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", o_result, e.res);
          check("err", MaxBits'(o_err), MaxBits'(e.err));
          check("valid_cycle", MaxBits'(cyc), MaxBits'(e.vcyc));
          check("busy_in_done", MaxBits'(o_busy), MaxBits'(1));
          last_res = e.res;
          hold_chk = 1'b1;
        end
      end
    end
  end

  task automatic scramble();
    i_mode = 2'($urandom());
    i_n = {8{$urandom()}};
    i_a = {8{$urandom()}};
    i_b = {8{$urandom()}};
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (q.size() != 0 && budget < 1000) begin
      @(posedge i_clk);
      budget++;
    end
    if (q.size() != 0) begin
      check("timeout", MaxBits'(q.size()), '0);
      q.delete();
    end
    @(posedge i_clk);
    #1;
  endtask

  // Issue one request; caller is in IDLE, just after a rising edge.
  task automatic do_op(input logic [1:0] mode, input logic [MaxBits-1:0] n,
                       input logic [MaxBits-1:0] a, input logic [MaxBits-1:0] b,
                       input logic [MaxBits-1:0] res, input bit err);
    exp_t e;
    i_mode  = mode;
    i_n     = n;
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    scramble();
    e.res  = res;
    e.err  = err;
    e.vcyc = cyc + lat_of(mode, a, err) - 1;
    q.push_back(e);
    wait_done();
  endtask

  logic [MaxBits-1:0] n25519;
  logic [MaxBits-1:0] hi;

  initial begin
    int acc;
    int acc2;
    int l5;
    exp_t e;
    n25519 = (MaxBits'(1) << 255) - MaxBits'(19);
    hi = MaxBits'(1) << 100;
    i_rst = 1'b1;
    i_start = 1'b1;
    i_mode = 2'd0;
    i_n = 97;
    i_a = 5;
    i_b = 7;
    repeat (3) @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_rst = 1'b0;
    check("rst_result", o_result, '0);
    check("rst_valid", MaxBits'(o_valid), '0);
    check("rst_busy", MaxBits'(o_busy), '0);
    check("rst_err", MaxBits'(o_err), '0);

    do_op(2'd0, 97, 5, 7, 35, 1'b0);
    do_op(2'd0, 97, 50, 3, 53, 1'b0);
    do_op(2'd0, 97, 200, 3, 18, 1'b0);          // a >= n is legal
    do_op(2'd0, 0, 5, 7, 0, 1'b1);              // n == 0
    do_op(2'd0, 97, 5, 100, 0, 1'b1);           // b >= n
    do_op(2'd0, 97, 5, 97, 0, 1'b1);            // b == n
    do_op(2'd0, 97, 96, 96, 1, 1'b0);           // b == n-1
    do_op(2'd0, 97, 0, 5, 0, 1'b0);
    do_op(2'd0, 97, 1, 5, 5, 1'b0);
    do_op(2'd0, 1, 3, 0, 0, 1'b0);              // n == 1
    do_op(2'd0, hi | 97, hi | 5, hi | 7, 35, 1'b0);  // bits above LEN ignored
    do_op(2'd1, 1000, 999, 999, 1, 1'b0);
    do_op(2'd2, 13, 12, 12, 1, 1'b0);
    do_op(2'd3, n25519, 2, 2, 4, 1'b0);
    do_op(2'd3, n25519, n25519 - 1, n25519 - 1, 1, 1'b0);  // (-1)^2 mod n

    // i_start held high; reset in RUN cycle 10 aborts the first operation.
    l5 = lat_of(2'd0, 5, 1'b0);
    i_mode = 2'd0;
    i_n = 97;
    i_a = 5;
    i_b = 7;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    acc = cyc;
`ifdef MODMUL_EARLY_EXIT_EN
    // Early exit finishes the first op before RUN cycle 10; expect its result.
    e.res = 35; e.err = 1'b0; e.vcyc = acc + l5 - 1;
    q.push_back(e);
    e.vcyc = acc + l5 + 1 + l5 - 1;
    q.push_back(e);
    while (cyc < acc + 9) @(posedge i_clk);
    #1;
    q.delete();
`else
    while (cyc < acc + 9) @(posedge i_clk);
    #1;
`endif
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    hold_chk = 1'b0;
    check("abort_result", o_result, '0);
    check("abort_busy", MaxBits'(o_busy), '0);
    check("abort_valid", MaxBits'(o_valid), '0);
    last_res = '0;
    @(posedge i_clk);
    #1;
    acc = cyc;
    e.res = 35; e.err = 1'b0; e.vcyc = acc + l5 - 1;
    q.push_back(e);
    acc2 = acc + l5 + 1;
    e.vcyc = acc2 + l5 - 1;
    q.push_back(e);
    while (cyc < acc2) @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_done();

    do_op(2'd0, 97, 50, 3, 53, 1'b0);
    repeat (3) @(posedge i_clk);
    #1;
    check("queue_empty", MaxBits'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_mul_iter.md
MOD_MUL_ITER -- requirements
Module: mod_mul_iter

Interface
REQ-001 SHALL have parameter MAX_BITS, default 256: maximum operand width; a multiple of 8.
REQ-002 SHALL have parameter DIGIT, default 1: bits of i_a consumed per RUN cycle; legal values 1, 2, 4.
REQ-003 SHALL have port i_clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_start, input, 1: request; sampled only in IDLE.
REQ-006 SHALL have port i_mode, input, 2: operand length LEN = MAX_BITS >> (3 - i_mode), so 00/01/10/11 = 32/64/128/256 at default.
REQ-007 SHALL have port i_n, input, MAX_BITS: modulus.
REQ-008 SHALL have ports i_a and i_b, input, MAX_BITS each: multiplicands.
REQ-009 SHALL have port o_result, output, MAX_BITS: (a*b) mod n, zero-extended above LEN.
REQ-010 SHALL have port o_valid, output, 1: one-cycle pulse when o_result is new.
REQ-011 SHALL have port o_busy, output, 1: high in RUN and DONE.
REQ-012 SHALL have port o_err, output, 1: operand error flag, qualified by o_valid.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on i_start with legal operands; RUN->DONE after the last digit; DONE->IDLE unconditionally after one cycle.
REQ-014 On start acceptance SHALL latch i_mode, LEN-masked i_n, i_a and i_b; later input changes SHALL NOT affect the operation.
REQ-015 Start acceptance SHALL clear accumulator m to 0 and load multiplicand register t with masked b.
REQ-016 Operands SHALL be illegal if masked n is 0 or masked b >= masked n; then IDLE->DONE with o_err=1 and o_result=0; o_valid SHALL be high on the first cycle after the start edge.
REQ-017 Each RUN cycle SHALL perform DIGIT LSB-first sub-steps: if the a bit is 1, m = m+t, minus n if the sum >= n; then t = 2t, minus n if >= n.
REQ-018 Intermediate sums SHALL be MAX_BITS+1 bits wide, with no overflow for any n < 2^MAX_BITS.
REQ-019 Without early exit, RUN SHALL last exactly LEN/DIGIT cycles, and o_valid SHALL be high on cycle LEN/DIGIT+1 after the start edge.
REQ-020 o_result and o_err SHALL be registered, SHALL update only on entry to DONE, and SHALL hold until the next DONE.
REQ-021 i_start SHALL be ignored while o_busy=1, including the DONE cycle; a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-022 i_mode changes during RUN SHALL have no effect.
REQ-023 Masked a >= n SHALL be legal; the result SHALL still be (a*b) mod n.

Reset
REQ-024 With i_rst=1 at a clock edge: state SHALL become IDLE; o_result=0, o_valid=0, o_busy=0, o_err=0; m, t and the digit counter SHALL be cleared.
REQ-025 Reset mid-RUN SHALL abort the operation with no o_valid pulse; a start on the first cycle after reset deasserts SHALL be accepted.
REQ-026 Reset SHALL take priority over i_start in the same cycle.

Configuration
REQ-027 Macro MODMUL_EARLY_EXIT_EN defined: in a RUN cycle where the unprocessed a bits after this cycle's sub-steps are all zero, the next state SHALL be DONE; o_valid SHALL come at cycle k+1, where k is the number of RUN cycles executed (minimum 1).
REQ-028 Macro MODMUL_EARLY_EXIT_EN undefined: RUN length SHALL be a fixed LEN/DIGIT cycles, independent of data; results SHALL be identical to the defined case.

Verification
REQ-029 DIGIT=1, mode 00, n=97, a=5, b=7 -> o_result=35, o_err=0, o_valid at cycle 33 without macro.
REQ-030 DIGIT=1, mode 00, n=97, a=50, b=3 -> o_result=53; a=200, b=3 -> o_result=18 (a >= n legal).
REQ-031 n=0, or n=97 with b=100 -> o_err=1, o_result=0, o_valid at cycle 1, o_busy high for 1 cycle.
REQ-032 Mode 11, n=2^255-19, a=2, b=2 -> o_result=4; valid at cycle 257 (DIGIT=1) or 129 (DIGIT=2) without macro.
REQ-033 i_start held high continuously, plus i_rst pulsed at RUN cycle 10 -> no o_valid for the aborted operation; back-to-back operations are accepted only in IDLE; each result is correct.
REQ-034 Macro defined, mode 00, n=97, a=1, b=5 -> o_result=5, o_valid at cycle 2; a=0 -> o_result=0, o_valid at cycle 2.
